// File: rtl/frame_bit_serializer_pkg.sv
// Shared constants and state encoding for the frame bit serializer slice.
package frame_bit_serializer_pkg;

  localparam int unsigned FRAME_W     = 16;
  localparam int unsigned SPS_DEFAULT = 8;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/frame_fifo.sv
// Small synchronous frame-word FIFO with occupancy count, registered full
// and a sticky overflow flag for dropped writes.
module frame_fifo
  import frame_bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = FRAME_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  next_count;
  logic              do_push;
  logic              do_pop;

  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign do_push   = push && ((count != OCC_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_comb begin
    next_count = count;
    case ({do_push, do_pop})
      2'b10:   next_count = count + OCC_W'(1);
      2'b01:   next_count = count - OCC_W'(1);
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= next_count;
      full  <= (next_count == OCC_W'(DEPTH));
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_bit_serializer.sv
// Buffers frame words and emits them LSB first, one bit per SPS samples,
// with sample index CNT, RAM_READY qualifier and end-of-frame pulse.
module frame_bit_serializer
  import frame_bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = FRAME_W,
  parameter int unsigned SPS        = SPS_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  output logic [DATA_W-1:0] FRAME_DATA,
  output logic              RAM_READY,
  output logic [CNT_W-1:0]  CNT,
  output logic              frame_done
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(SPS - 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  ser_state_t        state;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic              last_sample;
  logic              fifo_pop;

  assign last_sample = (state == SEND) && (CNT == CNT_LAST) && (bit_idx == BIT_LAST);
  assign fifo_pop    = !fifo_empty && ((state == IDLE) || last_sample);

  frame_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (full),
    .empty     (fifo_empty),
    .overflow  (overflow),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      FRAME_DATA <= '0;
      RAM_READY  <= 1'b0;
      CNT        <= '0;
      bit_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      // Set one edge early so the pulse coincides with the frame's last sample.
      frame_done <= (state == SEND) && (bit_idx == BIT_LAST) && (CNT == CNT_PENULT);
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            FRAME_DATA <= fifo_head;
            CNT        <= '0;
            bit_idx    <= '0;
            RAM_READY  <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (CNT != CNT_LAST) begin
            CNT <= CNT + CNT_W'(1);
          end else if (bit_idx != BIT_LAST) begin
            CNT        <= '0;
            FRAME_DATA <= FRAME_DATA >> 1;
            bit_idx    <= bit_idx + BIT_W'(1);
          end else if (!fifo_empty) begin
            FRAME_DATA <= fifo_head;
            CNT        <= '0;
            bit_idx    <= '0;
          end else begin
            FRAME_DATA <= '0;
            CNT        <= '0;
            bit_idx    <= '0;
            RAM_READY  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_occupancy_bound: assert property (@(posedge clk) disable iff (!reset)
    fifo_count <= OCC_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_frame_bit_serializer.sv
// Scoreboard bench: a frame-level reference model queues the expected sample
// stream per accepted word; a negedge monitor pops and compares.
module tb_frame_bit_serializer;

  localparam int W     = 16;
  localparam int SPS   = 8;
  localparam int DEPTH = 4;
  localparam int FL    = W * SPS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          full, overflow, RAM_READY, frame_done;
  logic [15:0]   FRAME_DATA;
  logic [2:0]    CNT;

  logic          wr_en2 = 1'b0;
  logic [15:0]   wr_data2 = '0;
  logic          full2, overflow2, RAM_READY2, frame_done2;
  logic [15:0]   FRAME_DATA2;
  logic [2:0]    CNT2;

  always #5 clk = ~clk;

  frame_bit_serializer #(.DATA_W(W), .SPS(SPS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .overflow(overflow), .FRAME_DATA(FRAME_DATA),
    .RAM_READY(RAM_READY), .CNT(CNT), .frame_done(frame_done)
  );

  frame_bit_serializer #(.DATA_W(W), .SPS(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .overflow(overflow2), .FRAME_DATA(FRAME_DATA2),
    .RAM_READY(RAM_READY2), .CNT(CNT2), .frame_done(frame_done2)
  );

  typedef struct {
    logic [15:0] fd;
    logic [2:0]  cnt;
    logic        done;
  } samp_t;

  samp_t       exp_q[$];
  logic [15:0] mq[$];
  int          m_pos = 0;
  bit          m_in = 0;
  bit          m_ovf = 0;
  bit          m_full = 0;
  int          vectors = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: word queue plus position within the frame on display.
  initial begin
    bit          last, pop, acc;
    logic [15:0] w;
    samp_t       s;
    forever begin
      @(posedge clk);
      if (!reset) begin
        exp_q.delete();
        mq.delete();
        m_in = 0; m_pos = 0; m_ovf = 0; m_full = 0;
      end else begin
        last = m_in && (m_pos == FL - 1);
        pop  = (!m_in || last) && (mq.size() != 0);
        acc  = wr_en && ((mq.size() < DEPTH) || pop);
        if (m_in && !last) begin
          m_pos++;
        end else if (pop) begin
          w = mq.pop_front();
          m_pos = 0;
          m_in  = 1;
          for (int i = 0; i < FL; i++) begin
            s.fd   = w >> (i / SPS);
            s.cnt  = 3'(i % SPS);
            s.done = (i == FL - 1);
            exp_q.push_back(s);
          end
        end else begin
          m_in = 0;
        end
        if (wr_en) begin
          if (acc) mq.push_back(wr_data);
          else     m_ovf = 1;
        end
        m_full = (mq.size() == DEPTH);
      end
    end
  end

  // Monitor
  initial begin
    samp_t s;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_ram_ready", 32'(RAM_READY), 32'd0);
        check("rst_frame_data", 32'(FRAME_DATA), 32'd0);
        check("rst_cnt", 32'(CNT), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
      end else begin
        if (exp_q.size() != 0) begin
          s = exp_q.pop_front();
          check("ram_ready", 32'(RAM_READY), 32'd1);
          check("frame_data", 32'(FRAME_DATA), 32'(s.fd));
          check("cnt", 32'(CNT), 32'(s.cnt));
          check("frame_done", 32'(frame_done), 32'(s.done));
        end else begin
          check("idle_ram_ready", 32'(RAM_READY), 32'd0);
          check("idle_frame_data", 32'(FRAME_DATA), 32'd0);
          check("idle_cnt", 32'(CNT), 32'd0);
          check("idle_frame_done", 32'(frame_done), 32'd0);
        end
        check("full", 32'(full), 32'(m_full));
        check("overflow", 32'(overflow), 32'(m_ovf));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_pos(input int p, input bit need_full);
    int budget = 4 * FL;
    while (!(m_in && m_pos == p && (!need_full || mq.size() == DEPTH)) && budget > 0) begin
      tick(1);
      budget--;
    end
    check("wait_pos_budget", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    tick(3);
    reset = 1'b1;
    tick(5);

    // Latency and single frame 16'hA5C3
    wr_en = 1'b1; wr_data = 16'hA5C3;
    tick(1);
    wr_en = 1'b0;
    check("lat_not_yet", 32'(RAM_READY), 32'd0);
    tick(1);
    check("lat_ready", 32'(RAM_READY), 32'd1);
    check("lat_cnt", 32'(CNT), 32'd0);
    check("lat_bit0", 32'(FRAME_DATA[0]), 32'd1);
    tick(FL + 10);

    // Back-to-back frames
    write(16'h0001); write(16'hFFFF); write(16'h8000);
    tick(3 * FL + 10);

    // Write into full FIFO on the end-of-frame pop
    for (int i = 0; i < 5; i++) write(16'($urandom));
    check("fill_full", 32'(full), 32'd1);
    wait_pos(FL - 1, 1'b1);
    wr_en = 1'b1; wr_data = 16'h5A5A;
    tick(1);
    wr_en = 1'b0;
    check("pop_write_full", 32'(full), 32'd1);
    check("pop_write_ovf", 32'(overflow), 32'd0);
    tick(5 * FL + 10);

    // Overflow: sixth write dropped
    for (int i = 0; i < 6; i++) write(16'($urandom));
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_set", 32'(overflow), 32'd1);
    tick(5 * FL + 10);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame at bit 7, CNT 3
    write(16'hC3A5);
    wait_pos(7 * SPS + 3, 1'b0);
    check("pre_rst_cnt", 32'(CNT), 32'd3);
    reset = 1'b0;
    #1;
    check("async_ram_ready", 32'(RAM_READY), 32'd0);
    check("async_frame_data", 32'(FRAME_DATA), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(10);
    check("post_rst_idle", 32'(RAM_READY), 32'd0);
    write(16'h1234);
    tick(1);
    check("restart_ready", 32'(RAM_READY), 32'd1);
    check("restart_cnt", 32'(CNT), 32'd0);
    check("restart_data", 32'(FRAME_DATA), 32'h1234);
    tick(FL + 10);

    // Randomized traffic, light then heavy
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 99) < ((i < 1500) ? 1 : 4));
      wr_data = 16'($urandom);
      tick(1);
    end
    wr_en = 1'b0;
    tick(6 * FL);

    // SPS=2 instance, word 16'h0003
    wr_en2 = 1'b1; wr_data2 = 16'h0003;
    tick(1);
    wr_en2 = 1'b0;
    tick(1);
    for (int i = 0; i < 32; i++) begin
      w = FRAME_DATA2;
      check("sps2_ready", 32'(RAM_READY2), 32'd1);
      check("sps2_bit", 32'(w[0]), 32'(i < 4));
      check("sps2_cnt", 32'(CNT2), 32'(i % 2));
      check("sps2_done", 32'(frame_done2), 32'(i == 31));
      tick(1);
    end
    check("sps2_end", 32'(RAM_READY2), 32'd0);
    check("sps2_ovf", 32'(overflow2), 32'd0);
    check("sps2_full", 32'(full2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/frame_bit_serializer.md
Name: frame_bit_serializer

Overview:
- Stage directly upstream of the I/Q cos-series mapper.
- Accepts 16-bit frame words from the host-side writer and buffers them in a small FIFO.
- Presents one frame bit at a time on FRAME_DATA[0] (LSB first), holding each bit for SPS sample clocks, with a sample index CNT and a RAM_READY qualifier.
- One instance per rail (I and Q).

Parameters:
- DATA_W, 16, frame word width; bits per frame.
- SPS, 8, samples per bit; legal 2..8, since the CNT port is 3 bits.
- FIFO_DEPTH, 4, frame words buffered; power of two, ≥2.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for wr_data.
- wr_data  input  16  frame word to enqueue.
- full  output  1  FIFO holds FIFO_DEPTH words.
- overflow  output  1  sticky: a write was dropped; cleared only by reset.
- FRAME_DATA  output  16  current frame shift register; bit 0 is the bit being sent.
- RAM_READY  output  1  high while FRAME_DATA[0]/CNT are valid.
- CNT  output  3  sample index within current bit, 0..SPS-1.
- frame_done  output  1  one-cycle pulse on the last sample of each frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empties; state=IDLE.
  - FRAME_DATA=0, RAM_READY=0, CNT=0, frame_done=0, overflow=0, full=0.
  - Bit index=0.
  - Reset mid-frame aborts the frame with no partial completion.
- FIFO:
  - Synchronous write/read pointers plus an occupancy count.
  - A write is accepted when occupancy<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow sets.
  - full is registered from the post-update occupancy.
- State machine, 2 states, all outputs registered:
  - IDLE:
    - RAM_READY=0, CNT=0, FRAME_DATA=0.
    - If FIFO non-empty at the edge: pop, FRAME_DATA←head word, CNT←0, bit index←0, RAM_READY←1, go SEND.
  - SEND, each edge:
    - If CNT<SPS-1: CNT←CNT+1; FRAME_DATA and bit index hold.
    - If CNT==SPS-1 and bit index<DATA_W-1: CNT←0, FRAME_DATA←FRAME_DATA>>1 (zero fill), bit index+1.
    - If CNT==SPS-1 and bit index==DATA_W-1:
      - frame_done=1 for this cycle (combinational on this condition, or registered one cycle earlier so it aligns with the last sample; aligned with last sample is required).
      - If FIFO non-empty: pop, load the next word, CNT←0, bit index←0, stay SEND. RAM_READY stays 1, with no gap sample.
      - Else: RAM_READY←0, FRAME_DATA←0, CNT←0, go IDLE.
- Latency:
  - wr_en sampled at edge t into an empty FIFO/IDLE block → RAM_READY=1, CNT=0 after edge t+1.
  - One frame occupies exactly DATA_W×SPS = 128 cycles with RAM_READY=1.
- Simultaneous write and pop when full: the write is accepted, occupancy stays FIFO_DEPTH, no overflow.
- Pointers wrap modulo FIFO_DEPTH; occupancy never exceeds FIFO_DEPTH or underflows.
- wr_en during reset is ignored.

Decomposition:
- Shared package holds:
  - localparam FRAME_W=16.
  - localparam SPS_DEFAULT=8.
  - CNT_W=3.
  - State encoding IDLE=1'b0, SEND=1'b1.
- One sub-module is natural: frame_fifo (sync FIFO, DATA_W × FIFO_DEPTH, with push/pop/full/empty/occupancy).
- The serializer FSM lives in the top module.

Test Plan:
- Reset then single write 16'hA5C3 at cycle 10:
  - RAM_READY rises after cycle 11.
  - FRAME_DATA[0] sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 8 cycles with CNT 0..7.
  - frame_done pulses once at cycle 11+128; RAM_READY falls the next edge.
- Three back-to-back writes (16'h0001, 16'hFFFF, 16'h8000):
  - 384 continuous RAM_READY cycles, no gap.
  - CNT wraps 7→0 at each frame boundary.
  - frame_done pulses 3 times, 128 cycles apart.
- Five writes while IDLE-to-SEND pops one word:
  - Four are held; full=1.
  - A sixth write with no pop is dropped: overflow=1 sticky.
  - The dropped word never appears on FRAME_DATA.
- Write when full in the same cycle as the end-of-frame pop: accepted, occupancy stays 4, overflow stays 0.
- Assert reset at bit 7, CNT=3 of a frame:
  - All outputs 0 immediately (asynchronous).
  - After release with an empty FIFO, RAM_READY stays 0.
  - A fresh write restarts at bit 0, CNT=0.
- SPS=2 build, write 16'h0003: FRAME_DATA[0]=1 for 4 cycles, then 0 for 28 cycles; frame length 32 cycles.
